// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and drives ALU control.
// Optional macro CTRL_BNE_EN: branch opcode with funct3=001 redirects the PC when Zero is clear (bne).
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on final wait cycle
// DECODE   | read registers, branch target into ALUOut
// MEMADR   | compute load/store address
// MEMREAD  | read data memory, held MEM_LAT extra cycles
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory
// EXECUTER | R-type ALU operation
// EXECUTEI | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare, conditional PC load from ALUOut
// JAL      | PC <= target, ALUOut <= PC+4
module multicycle_controller #(
   parameter int unsigned MEM_LAT = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [2:0] ALUControl,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [3:0] LAT = MEM_LAT[3:0];

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       wait_done;
   logic       br_taken;
   logic [1:0] alu_op;

   assign wait_done = (cnt == LAT);

`ifdef CTRL_BNE_EN
   assign br_taken = (funct3 == 3'b001) ? ~Zero : Zero;
`else
   assign br_taken = Zero;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_FETCH;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Counter only advances while holding in a wait state; any exit reloads it to 0.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         S_FETCH: begin
            if (wait_done) state_nxt = S_DECODE;
            else           cnt_nxt   = cnt + 4'd1;
         end
         S_DECODE: begin
            case (op)
               7'b0000011,
               7'b0100011: state_nxt = S_MEMADR;
               7'b0110011: state_nxt = S_EXECUTER;
               7'b0010011: state_nxt = S_EXECUTEI;
               7'b1101111: state_nxt = S_JAL;
               7'b1100011: state_nxt = S_BEQ;
               default:    state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: begin
            if (wait_done) state_nxt = S_MEMWB;
            else           cnt_nxt   = cnt + 4'd1;
         end
         S_MEMWB:    state_nxt = S_FETCH;
         S_MEMWRITE: state_nxt = S_FETCH;
         S_EXECUTER: state_nxt = S_ALUWB;
         S_EXECUTEI: state_nxt = S_ALUWB;
         S_ALUWB:    state_nxt = S_FETCH;
         S_BEQ:      state_nxt = S_FETCH;
         S_JAL:      state_nxt = S_ALUWB;
         default:    state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      RegWrite  = 1'b0;
      alu_op    = 2'b00;
      case (state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = wait_done;
            PCWrite   = wait_done;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            PCWrite = br_taken;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      // Reset has to silence every write strobe even before the state register has settled.
      if (!reset_n) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (op)
         7'b0100011: ImmSrc = 2'b01;
         7'b1100011: ImmSrc = 2'b10;
         7'b1101111: ImmSrc = 2'b11;
         default:    ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: one instance at MEM_LAT=0, one at MEM_LAT=2, per-cycle expected outputs.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero;

   logic       pcw_a, adr_a, mw_a, irw_a, rw_a, pcw_b, adr_b, mw_b, irw_b, rw_b;
   logic [1:0] rs_a, sa_a, sb_a, imm_a, rs_b, sa_b, sb_b, imm_b;
   logic [2:0] alu_a, alu_b;
   logic [15:0] out_a, out_b;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb_q[$];

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_LAT(0)) dut_a (
      .clk(clk), .reset_n(rst_a), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
      .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a), .ResultSrc(rs_a),
      .ALUControl(alu_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a), .RegWrite(rw_a));

   multicycle_controller #(.MEM_LAT(2)) dut_b (
      .clk(clk), .reset_n(rst_b), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
      .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b), .ResultSrc(rs_b),
      .ALUControl(alu_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b), .RegWrite(rw_b));

   assign out_a = {pcw_a, adr_a, mw_a, irw_a, rs_a, alu_a, sa_a, sb_a, imm_a, rw_a};
   assign out_b = {pcw_b, adr_b, mw_b, irw_b, rs_b, alu_b, sa_b, sb_b, imm_b, rw_b};

   function automatic logic [15:0] ev(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [2:0] alu,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic rw);
      return {pcw, adr, mw, irw, rs, alu, sa, sb, imm, rw};
   endfunction

   // Expected-value shorthands per state; imm is the ImmSrc for the current opcode.
   function automatic logic [15:0] x_fetch(input logic fin, input logic [1:0] imm);
      return ev(fin, 0, 0, fin, 2'b10, 3'b000, 2'b00, 2'b10, imm, 0);
   endfunction
   function automatic logic [15:0] x_decode(input logic [1:0] imm);
      return ev(0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, imm, 0);
   endfunction
   function automatic logic [15:0] x_aluwb(input logic [1:0] imm);
      return ev(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, imm, 1);
   endfunction

   task automatic chk(input string tag, input bit use_b, input logic [15:0] exp_v);
      logic [15:0] got, want;
      sb_q.push_back(exp_v);
      @(negedge clk);
      got  = use_b ? out_b : out_a;
      want = sb_q.pop_front();
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%h expected=%h", tag, got, want);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   // R/I-type on MEM_LAT=0 instance: FETCH, DECODE, EXECUTE, ALUWB.
   task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [2:0] alu_exp);
      set_instr(o, f3, f7, 1'b0);
      chk({tag, "_fetch"}, 0, x_fetch(1, 2'b00));
      chk({tag, "_decode"}, 0, x_decode(2'b00));
      chk({tag, "_exec"}, 0, ev(0, 0, 0, 0, 2'b00, alu_exp, 2'b10, o[5] ? 2'b00 : 2'b01, 2'b00, 0));
      chk({tag, "_wb"}, 0, x_aluwb(2'b00));
   endtask

   task automatic run_br(input string tag, input logic [2:0] f3, input logic z, input logic pcw_exp);
      set_instr(7'b1100011, f3, 1'b0, z);
      chk({tag, "_fetch"}, 0, x_fetch(1, 2'b10));
      chk({tag, "_decode"}, 0, x_decode(2'b10));
      chk({tag, "_beq"}, 0, ev(pcw_exp, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, 2'b10, 0));
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("rst_c1", 0, x_fetch(0, 2'b00));
      chk("rst_c2", 0, x_fetch(0, 2'b00));
      rst_a = 1'b1;

      run_alu("add",  7'b0110011, 3'b000, 1'b0, 3'b000);
      run_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
      run_alu("or",   7'b0110011, 3'b110, 1'b0, 3'b011);
      run_alu("and",  7'b0110011, 3'b111, 1'b0, 3'b010);
      run_alu("slt",  7'b0110011, 3'b010, 1'b0, 3'b101);
      run_alu("xor",  7'b0110011, 3'b100, 1'b0, 3'b000);
      run_alu("slti", 7'b0010011, 3'b010, 1'b0, 3'b101);
      run_alu("addi_f7", 7'b0010011, 3'b000, 1'b1, 3'b000);

      run_br("beq_z1", 3'b000, 1'b1, 1'b1);
      run_br("beq_z0", 3'b000, 1'b0, 1'b0);
`ifdef CTRL_BNE_EN
      run_br("bne_z0", 3'b001, 1'b0, 1'b1);
      run_br("bne_z1", 3'b001, 1'b1, 1'b0);
`else
      run_br("bne_z0", 3'b001, 1'b0, 1'b0);
      run_br("bne_z1", 3'b001, 1'b1, 1'b1);
`endif

      set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
      chk("ill_fetch", 0, x_fetch(1, 2'b00));
      chk("ill_decode", 0, x_decode(2'b00));

      set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
      chk("jal_fetch", 0, x_fetch(1, 2'b11));
      chk("jal_decode", 0, x_decode(2'b11));
      chk("jal_jal", 0, ev(1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b11, 0));
      chk("jal_wb", 0, x_aluwb(2'b11));

      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      chk("sw_fetch", 0, x_fetch(1, 2'b01));
      chk("sw_decode", 0, x_decode(2'b01));
      chk("sw_adr", 0, ev(0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b01, 0));
      chk("sw_write", 0, ev(0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0));

      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      chk("lw0_fetch", 0, x_fetch(1, 2'b00));
      chk("lw0_decode", 0, x_decode(2'b00));
      chk("lw0_adr", 0, ev(0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0));
      chk("lw0_read", 0, ev(0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0));
      chk("lw0_wb", 0, ev(0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1));

      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      chk("swr_fetch", 0, x_fetch(1, 2'b01));
      chk("swr_decode", 0, x_decode(2'b01));
      chk("swr_adr", 0, ev(0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b01, 0));
      rst_a = 1'b0;
      chk("swr_write_rst", 0, ev(0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0));
      chk("swr_after_rst", 0, x_fetch(0, 2'b01));
      rst_a = 1'b1;
      chk("swr_release", 0, x_fetch(1, 2'b01));

      // MEM_LAT=2 instance: lw with stretched FETCH and MEMREAD.
      rst_a = 1'b0;
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      chk("b_rst", 1, x_fetch(0, 2'b00));
      rst_b = 1'b1;
      chk("lw2_fetch0", 1, x_fetch(0, 2'b00));
      chk("lw2_fetch1", 1, x_fetch(0, 2'b00));
      chk("lw2_fetch2", 1, x_fetch(1, 2'b00));
      chk("lw2_decode", 1, x_decode(2'b00));
      chk("lw2_adr", 1, ev(0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0));
      for (int i = 0; i < 3; i++)
         chk($sformatf("lw2_read%0d", i), 1, ev(0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0));
      chk("lw2_wb", 1, ev(0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1));
      chk("lw2_next0", 1, x_fetch(0, 2'b00));
      chk("lw2_next1", 1, x_fetch(0, 2'b00));
      chk("lw2_next2", 1, x_fetch(1, 2'b00));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
